fxp_mult_arbiter: RTL and testbench

Round-robin arbiter and pipelined signed fixed-point multiplier shared by the Kalman datapath clients: state prediction/update and covariance prediction/gain/update. The Kalman top level instantiates it so that these units time-share one WIDTH×WIDTH multiplier instead of each holding its own. It accepts one product per enabled cycle and returns results tagged with the requester index.

---
 rtl/fxp_mult_arbiter.sv | 152 +++++++++++++++
 tb/tb_fxp_mult_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_mult_arbiter.sv
// Round-robin arbiter in front of one shared pipelined signed fixed-point multiplier.
// Results return LAT enabled edges after transfer, tagged with the requester index.
module fxp_mult_arbiter #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned intDigits = 5,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned LAT       = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic [NREQ-1:0]          req,
  input  logic [WIDTH-1:0]         op_a [0:NREQ-1],
  input  logic [WIDTH-1:0]         op_b [0:NREQ-1],
  output logic [NREQ-1:0]          gnt,
  output logic [WIDTH-1:0]         result,
  output logic                     result_valid,
  output logic [$clog2(NREQ)-1:0]  result_id,
  output logic                     sat,
  output logic                     idle
);

  localparam int unsigned FRAC = WIDTH - intDigits;
  localparam int unsigned IDW  = $clog2(NREQ);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] scan_idx;
  logic           gnt_any;

  logic             s1_vld_q;
  logic [IDW-1:0]   s1_id_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shifted;
  logic [WIDTH:0]            hi_bits;
  logic [WIDTH-1:0]          s1_res;
  logic                      s1_sat;
  logic                      pipe_busy;

  // Scan from ptr upward with wrap; first requester found wins.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    if (!reset && clk_en) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        scan_idx = IDW'((32'(ptr_q) + k) % NREQ);
        if (!gnt_any && req[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_idx;
        end
      end
      if (gnt_any) begin
        gnt[gnt_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_id_q  <= '0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
    end else if (clk_en) begin
      ptr_q    <= ptr_d;
      s1_vld_q <= gnt_any;
      if (gnt_any) begin
        s1_id_q <= gnt_idx;
        s1_a_q  <= op_a[gnt_idx];
        s1_b_q  <= op_b[gnt_idx];
      end
    end
  end

  // In range iff the bits from the result sign upward are all equal.
  always_comb begin
    prod    = $signed(s1_a_q) * $signed(s1_b_q);
    shifted = prod >>> FRAC;
    hi_bits = shifted[2*WIDTH-1:WIDTH-1];
    s1_res  = shifted[WIDTH-1:0];
    s1_sat  = 1'b0;
    if (!((&hi_bits) || !(|hi_bits))) begin
      s1_sat = 1'b1;
      s1_res = shifted[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  if (LAT == 1) begin : g_direct
    assign result       = s1_res;
    assign sat          = s1_sat;
    assign result_id    = s1_id_q;
    assign result_valid = s1_vld_q;
    assign pipe_busy    = 1'b0;
  end else begin : g_pipe
    logic [WIDTH-1:0] res_q [1:LAT-1];
    logic             sat_q [1:LAT-1];
    logic [IDW-1:0]   id_q  [1:LAT-1];
    logic             vld_q [1:LAT-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int j = 1; j < int'(LAT); j++) begin
          res_q[j] <= '0;
          sat_q[j] <= 1'b0;
          id_q[j]  <= '0;
          vld_q[j] <= 1'b0;
        end
      end else if (clk_en) begin
        res_q[1] <= s1_res;
        sat_q[1] <= s1_sat;
        id_q[1]  <= s1_id_q;
        vld_q[1] <= s1_vld_q;
        for (int j = 2; j < int'(LAT); j++) begin
          res_q[j] <= res_q[j-1];
          sat_q[j] <= sat_q[j-1];
          id_q[j]  <= id_q[j-1];
          vld_q[j] <= vld_q[j-1];
        end
      end
    end

    always_comb begin
      pipe_busy = 1'b0;
      for (int j = 1; j < int'(LAT); j++) begin
        pipe_busy = pipe_busy | vld_q[j];
      end
    end

    assign result       = res_q[LAT-1];
    assign sat          = sat_q[LAT-1];
    assign result_id    = id_q[LAT-1];
    assign result_valid = vld_q[LAT-1];
  end

  assign idle = (req == '0) && !s1_vld_q && !pipe_busy;

  a_gnt_onehot : assert property (@(posedge clk) $onehot0(gnt));
  a_gnt_req    : assert property (@(posedge clk) (gnt & ~req) == '0);

endmodule

// File: tb/tb_fxp_mult_arbiter.sv
// Directed bench for fxp_mult_arbiter: arithmetic vector table plus arbitration,
// clk_en gating and mid-pipeline reset sequences.
module tb_fxp_mult_arbiter;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic [3:0]  req;
  logic [15:0] op_a [0:3];
  logic [15:0] op_b [0:3];
  logic [3:0]  gnt;
  logic [15:0] result;
  logic        result_valid;
  logic [1:0]  result_id;
  logic        sat;
  logic        idle;

  int n_cmp;
  int n_fail;

  fxp_mult_arbiter #(
    .WIDTH(16), .intDigits(5), .NREQ(4), .LAT(2)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .req(req),
    .op_a(op_a), .op_b(op_b), .gnt(gnt), .result(result),
    .result_valid(result_valid), .result_id(result_id), .sat(sat), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        s;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    // a, b, expected result, expected sat (Q5.11)
    vecs[0] = '{16'd4096,  16'd6144,  16'd12288, 1'b0};  // 2.0 * 3.0
    vecs[1] = '{16'd16384, 16'd8192,  16'h7FFF,  1'b1};  // 8 * 4 overflows
    vecs[2] = '{16'hF400,  16'd4096,  16'hE800,  1'b0};  // -3072*4096 -> -6144
    vecs[3] = '{16'd1,     16'd1,     16'h0000,  1'b0};
    vecs[4] = '{16'hFFFF,  16'd1,     16'hFFFF,  1'b0};  // floor(-1/2048) = -1
    vecs[5] = '{16'h8000,  16'h8000,  16'h7FFF,  1'b1};
    vecs[6] = '{16'h8000,  16'h7FFF,  16'h8000,  1'b1};  // negative clip
    vecs[7] = '{16'h7FFF,  16'h0800,  16'h7FFF,  1'b0};  // max * 1.0, exact fit
    vecs[8] = '{16'hFFFD,  16'h0400,  16'hFFFE,  1'b0};  // -1.5 floors to -2
    vecs[9] = '{16'h0800,  16'h0800,  16'h0800,  1'b0};  // 1.0 * 1.0

    reset  = 1'b1;
    clk_en = 1'b1;
    req    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    tick();
    req = 4'b1111;
    #1;
    chk("gnt_in_reset", gnt, 4'b0000);
    tick();
    req = 4'b0000;
    reset = 1'b0;
    #1;
    chk("rst_result", result, 16'h0);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_id", result_id, 2'd0);
    chk("rst_sat", sat, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_ptr", dut.ptr_q, 2'd0);

    // Arithmetic table, one transfer at a time across rotating requesters
    for (int i = 0; i < 10; i++) begin
      automatic int id = i % 4;
      req = 4'b0000;
      req[id] = 1'b1;
      op_a[id] = vecs[i].a;
      op_b[id] = vecs[i].b;
      #1;
      chk("vec_gnt", gnt, 32'(1) << id);
      chk("vec_busy", idle, 1'b0);
      tick();
      req = 4'b0000;
      #1;
      chk("vec_early", result_valid, 1'b0);
      tick();
      chk("vec_valid", result_valid, 1'b1);
      chk("vec_result", result, vecs[i].res);
      chk("vec_sat", sat, vecs[i].s);
      chk("vec_id", result_id, id);
      tick();
      chk("vec_pulse", result_valid, 1'b0);
      chk("vec_idle", idle, 1'b1);
    end

    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Four simultaneous requesters, each drops after its transfer
    for (int i = 0; i < 4; i++) begin
      op_a[i] = 16'((i + 1) * 2048);
      op_b[i] = 16'd4096;
    end
    req = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("all_gnt", gnt, (c < 4) ? (32'(1) << c) : 32'(0));
      tick();
      if (c < 4) req[c] = 1'b0;
      if (c >= 1 && c <= 4) begin
        chk("all_valid", result_valid, 1'b1);
        chk("all_id", result_id, c - 1);
        chk("all_result", result, 32'(c * 4096));
      end else begin
        chk("all_quiet", result_valid, 1'b0);
      end
    end
    chk("all_ptr", dut.ptr_q, 2'd0);

    // Fairness between requesters 0 and 2 held continuously
    op_a[0] = 16'h0800; op_b[0] = 16'h0800;
    op_a[2] = 16'h0800; op_b[2] = 16'hF800;
    req = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("fair_gnt", gnt, (c % 2 == 0) ? 32'h1 : 32'h4);
      tick();
      if (c >= 1) begin
        chk("fair_id", result_id, ((c - 1) % 2 == 0) ? 0 : 2);
        chk("fair_result", result, ((c - 1) % 2 == 0) ? 32'h0800 : 32'hF800);
      end
    end
    req = 4'b0000;
    tick();
    tick();
    chk("fair_drain", result_valid, 1'b0);

    // clk_en gating: ptr is 3, so requester 1 wins after wrap
    op_a[1] = 16'd4096; op_b[1] = 16'd6144;
    req = 4'b0010;
    #1;
    chk("en_gnt", gnt, 4'b0010);
    tick();
    req = 4'b1000;
    clk_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("en_gnt_off", gnt, 4'b0000);
      tick();
      chk("en_frozen", result_valid, 1'b0);
    end
    req = 4'b0000;
    clk_en = 1'b1;
    tick();
    chk("en_valid", result_valid, 1'b1);
    chk("en_result", result, 16'd12288);
    chk("en_id", result_id, 2'd1);
    clk_en = 1'b0;
    tick();
    chk("en_hold_valid", result_valid, 1'b1);
    clk_en = 1'b1;
    tick();
    chk("en_pulse_end", result_valid, 1'b0);

    // Reset with two transfers issued; the second is still in flight
    op_a[0] = 16'd2048; op_b[0] = 16'd2048;
    op_a[2] = 16'd4096; op_b[2] = 16'd4096;
    req = 4'b0101;
    tick();
    req[0] = 1'b0;
    tick();
    req = 4'b0010;
    reset = 1'b1;
    #1;
    chk("rstmid_gnt", gnt, 4'b0000);
    tick();
    chk("rstmid_valid0", result_valid, 1'b0);
    chk("rstmid_ptr", dut.ptr_q, 2'd0);
    reset = 1'b0;
    req = 4'b0000;
    tick();
    chk("rstmid_valid1", result_valid, 1'b0);
    chk("rstmid_idle", idle, 1'b1);
    tick();
    chk("rstmid_valid2", result_valid, 1'b0);
    op_a[3] = 16'd6144; op_b[3] = 16'd2048;
    req = 4'b1000;
    #1;
    chk("rstmid_gnt3", gnt, 4'b1000);
    tick();
    req = 4'b0000;
    tick();
    chk("rstmid_valid3", result_valid, 1'b1);
    chk("rstmid_id3", result_id, 2'd3);
    chk("rstmid_res3", result, 16'd6144);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
